// File: rtl/spi_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_bus_arbiter_pkg
// Purpose : Shared types and helpers for the SPI bus arbiter slice.
//           Holds the transfer FSM state encoding, the default word width,
//           a one-hot to index helper and a constant max helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package spi_bus_arbiter_pkg;

  localparam int DEFAULT_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  // OR-reduction of the set bit positions; exact for a one-hot (or zero) vector.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_bus_arbiter_if
// Purpose : Client request/response and SPI engine handshake bundle.
// Ports   : req, req_data           client requests and tx words
//           gnt, rsp_valid, rsp_err,
//           rsp_data, cs_n          client side results / chip selects
//           spi_start, spi_tx       commands to the shift engine
//           spi_done, spi_rx        completion from the shift engine
//           modport master = arbiter side, modport slave = clients/engine
// Rev     : 1.0  initial release
// ============================================================================
interface spi_bus_arbiter_if
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DEFAULT_DW
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_valid;
  logic               rsp_err;
  logic [DW-1:0]      rsp_data;
  logic [NREQ-1:0]    cs_n;
  logic               spi_start;
  logic [DW-1:0]      spi_tx;
  logic               spi_done;
  logic [DW-1:0]      spi_rx;

  modport master (
    input  req, req_data, spi_done, spi_rx,
    output gnt, rsp_valid, rsp_err, rsp_data, cs_n, spi_start, spi_tx
  );

  modport slave (
    output req, req_data, spi_done, spi_rx,
    input  gnt, rsp_valid, rsp_err, rsp_data, cs_n, spi_start, spi_tx
  );
endinterface
`default_nettype wire

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin pick: first set request at or after
//           the pointer, wrapping NREQ-1 -> 0.
// Ports   : req_i    request vector
//           ptr_i    round-robin start position
//           valid_o  any request present
//           gnt_o    one-hot pick
//           idx_o    index of the pick
// Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            valid_o,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  always_comb begin
    int          slot;
    logic [IW-1:0] slot_idx;
    gnt_o    = '0;
    slot     = 0;
    slot_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      slot = int'(ptr_i) + k;
      if (slot >= NREQ) slot = slot - NREQ;
      slot_idx = IW'(slot);
      if (gnt_o == '0 && req_i[slot_idx]) gnt_o[slot_idx] = 1'b1;
    end
  end

  assign valid_o = |req_i;
  assign idx_o   = IW'(onehot_to_idx(8'(gnt_o)));

endmodule
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : spi_bus_arbiter
// Purpose : Shares one SPI shift engine between NREQ clients. Round-robin
//           grant, per-client active-low chip select, transfer sequence
//           SETUP -> START -> WAIT -> HOLD -> GAP, with a WAIT timeout.
// Ports   : clk    system clock (rising edge)
//           rst_n  asynchronous active-low reset
//           bus    spi_bus_arbiter_if.master (requests, responses, engine)
// Rev     : 1.0  initial release
// ============================================================================
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DW       = DEFAULT_DW,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 1,
  parameter int TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_bus_arbiter_if.master     bus
);

  localparam int IW   = $clog2(NREQ);
  localparam int MAXC = max_of(max_of(CS_SETUP, CS_HOLD), max_of(GAP, TIMEOUT));
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SETUP_LAST   = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] OWNER_LAST   = IW'(NREQ - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   rr_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] cs_n_q;
  logic            spi_start_q;
  logic [DW-1:0]   spi_tx_q;
  logic [DW-1:0]   rx_q;
  logic            err_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic            rsp_err_q;
  logic [DW-1:0]   rsp_data_q;

  logic            w_pick_valid;
  logic [NREQ-1:0] w_pick_gnt;
  logic [IW-1:0]   w_pick_idx;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i   (bus.req),
    .ptr_i   (rr_q),
    .valid_o (w_pick_valid),
    .gnt_o   (w_pick_gnt),
    .idx_o   (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= '0;
      rr_q        <= '0;
      gnt_q       <= '0;
      cs_n_q      <= '1;
      spi_start_q <= 1'b0;
      spi_tx_q    <= '0;
      rx_q        <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      // Pulse outputs default low; set only in the one cycle they apply.
      spi_start_q <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (w_pick_valid) begin
            owner_q  <= w_pick_idx;
            gnt_q    <= w_pick_gnt;
            cs_n_q   <= ~w_pick_gnt;
            spi_tx_q <= bus.req_data[w_pick_idx*DW +: DW];
            rx_q     <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_START;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_START: begin
          spi_start_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.spi_done) begin
            rx_q    <= bus.spi_rx;
            cnt_q   <= '0;
            state_q <= ST_HOLD;
          end else if (cnt_q == TIMEOUT_LAST) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            gnt_q       <= '0;
            cs_n_q      <= '1;
            rsp_valid_q <= gnt_q;
            rsp_err_q   <= err_q;
            rsp_data_q  <= err_q ? '0 : rx_q;
            rr_q        <= (owner_q == OWNER_LAST) ? '0 : owner_q + IW'(1);
            cnt_q       <= '0;
            state_q     <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.spi_start = spi_start_q;
  assign bus.spi_tx    = spi_tx_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
`default_nettype wire
